// File: rtl/rv_pipe_pkg.sv
// Shared pipeline-control types for the RV32I core family: stage indices,
// the per-stage hazard shadow entry, and the forward-select encoding.
package rv_pipe_pkg;

    localparam int STG_IF = 0;
    localparam int STG_ID = STG_IF + 1;
    localparam int STG_EX = STG_ID + 1;

    // Shadow rd is stored at a fixed width; narrower register files zero-extend.
    localparam int RA_MAX_W = 8;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [RA_MAX_W-1:0] rd;
        logic                wen;
        logic                is_load;
    } shadow_entry_t;

endpackage

// File: rtl/pipe_fwd_match.sv
// Finds the youngest downstream stage (EX..WB) that will write a given source
// register; returns hit, that stage index as the forward select, and whether it is a load.
module pipe_fwd_match
    import rv_pipe_pkg::*;
#(
    parameter int NSTAGES = 5,
    parameter int SEL_W   = 3
) (
    input  shadow_entry_t [NSTAGES-1:STG_EX] shadow,
    input  logic [RA_MAX_W-1:0]              rs,
    input  logic                             rs_used,
    output logic                             hit,
    output logic [SEL_W-1:0]                 sel,
    output logic                             is_load
);

    // Walk from WB toward EX so the last match written is the youngest producer.
    always_comb begin
        hit     = 1'b0;
        sel     = SEL_W'(FWD_RF);
        is_load = 1'b0;
        if (rs_used && (rs != '0)) begin
            for (int k = NSTAGES - 1; k >= STG_EX; k--) begin
                if (shadow[k].valid && shadow[k].wen && (shadow[k].rd == rs)) begin
                    hit     = 1'b1;
                    sel     = SEL_W'(k);
                    is_load = shadow[k].is_load;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Depth-generic hazard tracker: shadows EX..WB, drives forwarding, load-use stalls,
// memory-wait freeze and redirect flush. Optional counters under PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int NSTAGES = 5,
    parameter int RA_W    = 5,
    parameter int SEL_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [RA_W-1:0]    id_rs1,
    input  logic [RA_W-1:0]    id_rs2,
    input  logic               id_rs1_used,
    input  logic               id_rs2_used,
    input  logic [RA_W-1:0]    id_rd,
    input  logic               id_wen,
    input  logic               id_is_load,
    input  logic               redirect,
    input  logic               mem_wait,
    output logic               stall_if,
    output logic               stall_id,
    output logic               bubble_ex,
    output logic               flush_if,
    output logic               flush_id,
    output logic               freeze_all,
    output logic [SEL_W-1:0]   fwd_rs1_sel,
    output logic [SEL_W-1:0]   fwd_rs2_sel,
    output logic [NSTAGES-3:0] stage_valid
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]        cnt_loaduse,
    output logic [31:0]        cnt_flush,
    output logic [31:0]        cnt_memwait
`endif
);

    localparam logic [SEL_W-1:0] SEL_WB = SEL_W'(NSTAGES - 1);

    shadow_entry_t [NSTAGES-1:STG_EX] shadow_q;
    shadow_entry_t                    id_entry;
    logic                             hit1, hit2, ld1, ld2;
    logic [SEL_W-1:0]                 sel1, sel2;
    logic                             load_use;
    logic                             issue;

    assign id_entry = '{valid: 1'b1, rd: RA_MAX_W'(id_rd), wen: id_wen, is_load: id_is_load};

    pipe_fwd_match #(.NSTAGES(NSTAGES), .SEL_W(SEL_W)) u_fwd_rs1 (
        .shadow  (shadow_q),
        .rs      (RA_MAX_W'(id_rs1)),
        .rs_used (id_rs1_used),
        .hit     (hit1),
        .sel     (sel1),
        .is_load (ld1)
    );

    pipe_fwd_match #(.NSTAGES(NSTAGES), .SEL_W(SEL_W)) u_fwd_rs2 (
        .shadow  (shadow_q),
        .rs      (RA_MAX_W'(id_rs2)),
        .rs_used (id_rs2_used),
        .hit     (hit2),
        .sel     (sel2),
        .is_load (ld2)
    );

    // Load data only exists in WB, so a load producer anywhere earlier must stall.
    assign load_use = id_valid & ((hit1 & ld1 & (sel1 != SEL_WB)) |
                                  (hit2 & ld2 & (sel2 != SEL_WB)));

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        freeze_all  = 1'b0;
        fwd_rs1_sel = SEL_W'(FWD_RF);
        fwd_rs2_sel = SEL_W'(FWD_RF);
        if (!rst) begin
            fwd_rs1_sel = sel1;
            fwd_rs2_sel = sel2;
            if (mem_wait) begin
                freeze_all = 1'b1;
                stall_if   = 1'b1;
                stall_id   = 1'b1;
            end else if (redirect) begin
                flush_if = 1'b1;
                flush_id = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    assign issue = id_valid & ~stall_id & ~redirect;

    // Shadow shift: EX takes the issued ID entry or a bubble, the rest move down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (!freeze_all) begin
            shadow_q[STG_EX] <= issue ? id_entry : '0;
            for (int k = STG_EX + 1; k < NSTAGES; k++) begin
                shadow_q[k] <= shadow_q[k-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NSTAGES - 2; i++) begin
            stage_valid[i] = shadow_q[i+STG_EX].valid;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_loaduse <= '0;
            cnt_flush   <= '0;
            cnt_memwait <= '0;
        end else begin
            cnt_loaduse <= sat_inc(cnt_loaduse, bubble_ex);
            cnt_flush   <= sat_inc(cnt_flush, flush_if);
            cnt_memwait <= sat_inc(cnt_memwait, freeze_all);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a 5-stage and a 7-stage instance share stimulus and are
// compared against a per-stage occupancy model. Build with PIPE_PERF_CNT_EN to cover counters.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_used, id_rs2_used, id_wen, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       redirect, mem_wait;

    logic       a_sif, a_sid, a_bub, a_fif, a_fid, a_frz;
    logic       b_sif, b_sid, b_bub, b_fif, b_fid, b_frz;
    logic [2:0] a_sel1, a_sel2, b_sel1, b_sel2;
    logic [2:0] a_sv;
    logic [4:0] b_sv;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] a_clu, a_cfl, a_cmw, b_clu, b_cfl, b_cmw;
`endif

    wire [5:0] a_ctrl = {a_sif, a_sid, a_bub, a_fif, a_fid, a_frz};
    wire [5:0] b_ctrl = {b_sif, b_sid, b_bub, b_fif, b_fid, b_frz};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NSTAGES(5), .RA_W(5), .SEL_W(3)) dut5 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_wen(id_wen), .id_is_load(id_is_load), .redirect(redirect), .mem_wait(mem_wait),
        .stall_if(a_sif), .stall_id(a_sid), .bubble_ex(a_bub), .flush_if(a_fif),
        .flush_id(a_fid), .freeze_all(a_frz), .fwd_rs1_sel(a_sel1), .fwd_rs2_sel(a_sel2),
        .stage_valid(a_sv)
`ifdef PIPE_PERF_CNT_EN
        , .cnt_loaduse(a_clu), .cnt_flush(a_cfl), .cnt_memwait(a_cmw)
`endif
    );

    pipe_hazard_ctrl #(.NSTAGES(7), .RA_W(5), .SEL_W(3)) dut7 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_wen(id_wen), .id_is_load(id_is_load), .redirect(redirect), .mem_wait(mem_wait),
        .stall_if(b_sif), .stall_id(b_sid), .bubble_ex(b_bub), .flush_if(b_fif),
        .flush_id(b_fid), .freeze_all(b_frz), .fwd_rs1_sel(b_sel1), .fwd_rs2_sel(b_sel2),
        .stage_valid(b_sv)
`ifdef PIPE_PERF_CNT_EN
        , .cnt_loaduse(b_clu), .cnt_flush(b_cfl), .cnt_memwait(b_cmw)
`endif
    );

    // Reference model: what each pipeline slot currently holds, per configuration.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
    } rec_t;

    rec_t md [2][8];
    int   pc_lu [2];
    int   pc_fl [2];
    int   pc_mw [2];

    function automatic int nst(input int d);
        return (d == 0) ? 5 : 7;
    endfunction

    // Scan from the stage just after ID downward; the first writer found is the youngest.
    function automatic logic [2:0] esel(input int d, input logic [4:0] rs, input logic used);
        if (!used || rs == 5'd0) return 3'd0;
        for (int k = 2; k < nst(d); k++)
            if (md[d][k].v && md[d][k].wen && md[d][k].rd == rs) return 3'(k);
        return 3'd0;
    endfunction

    function automatic bit elu(input int d);
        logic [2:0] s1, s2;
        if (!id_valid) return 1'b0;
        s1 = esel(d, id_rs1, id_rs1_used);
        s2 = esel(d, id_rs2, id_rs2_used);
        if (s1 != 0 && md[d][s1].ld && int'(s1) < nst(d) - 1) return 1'b1;
        if (s2 != 0 && md[d][s2].ld && int'(s2) < nst(d) - 1) return 1'b1;
        return 1'b0;
    endfunction

    // {stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze_all}
    function automatic logic [5:0] ectrl(input int d);
        if (rst)      return 6'b000000;
        if (mem_wait) return 6'b110001;
        if (redirect) return 6'b000110;
        if (elu(d))   return 6'b111000;
        return 6'b000000;
    endfunction

    function automatic logic [7:0] esv(input int d);
        logic [7:0] r = 8'd0;
        for (int k = 2; k < nst(d); k++) r[k-2] = md[d][k].v;
        return r;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) md[d][k] = '0;
            pc_lu[d] = 0; pc_fl[d] = 0; pc_mw[d] = 0;
        end
    endtask

    task automatic tick();
        logic [5:0] c [2];
        for (int d = 0; d < 2; d++) c[d] = ectrl(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (c[d][5] && c[d][3]) pc_lu[d]++;
            if (c[d][2]) pc_fl[d]++;
            if (c[d][0]) pc_mw[d]++;
            if (!mem_wait && !rst) begin
                for (int k = nst(d) - 1; k > 2; k--) md[d][k] = md[d][k-1];
                if (id_valid && !c[d][4] && !redirect)
                    md[d][2] = '{v: 1'b1, rd: id_rd, wen: id_wen, ld: id_is_load};
                else
                    md[d][2] = '0;
            end
        end
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic wen, input logic ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_wen = wen; id_is_load = ld;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        redirect = 0; mem_wait = 0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_id(1, 5'd3, 5'd4, 1, 1, 5'd3, 1, 1);
        redirect = 1; mem_wait = 1;
        #2;
        checks++;
        if (a_ctrl !== 6'd0 || b_ctrl !== 6'd0) begin
            errors++; $display("FAIL reset_ctrl got %b/%b want 000000", a_ctrl, b_ctrl);
        end
        checks++;
        if (a_sv !== 3'd0 || b_sv !== 5'd0 || a_sel1 !== 3'd0 || b_sel2 !== 3'd0) begin
            errors++; $display("FAIL reset_state sv %b/%b sel %0d/%0d want 0", a_sv, b_sv, a_sel1, b_sel2);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (a_cmw !== 32'd0 || b_clu !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d want 0", a_cmw, b_clu);
        end
`endif
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        redirect = 0; mem_wait = 0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fwd_basic();
        drain();
        set_id(1, 0, 0, 0, 0, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd5, 0, 1, 0, 5'd6, 1, 0);
        #1;
        checks++;
        if (a_sel1 !== 3'd2 || b_sel1 !== 3'd2) begin
            errors++; $display("FAIL fwd_ex_sel got %0d/%0d want 2", a_sel1, b_sel1);
        end
        checks++;
        if (a_ctrl !== 6'd0 || b_ctrl !== 6'd0) begin
            errors++; $display("FAIL fwd_ex_nostall got %b/%b want 000000", a_ctrl, b_ctrl);
        end
        tick();
    endtask

    task automatic test_load_use();
        int  st5 = 0, st7 = 0;
        bit  rel5 = 0, rel7 = 0;
        drain();
        set_id(1, 0, 0, 0, 0, 5'd5, 1, 1);
        tick();
        set_id(1, 5'd5, 0, 1, 0, 5'd6, 1, 0);
        for (int cyc = 0; cyc < 12 && !(rel5 && rel7); cyc++) begin
            #1;
            checks++;
            if (a_ctrl !== ectrl(0) || b_ctrl !== ectrl(1)) begin
                errors++; $display("FAIL lu_ctrl cyc%0d got %b/%b want %b/%b", cyc, a_ctrl, b_ctrl, ectrl(0), ectrl(1));
            end
            checks++;
            if (8'(b_sv) !== esv(1)) begin
                errors++; $display("FAIL lu_walk7 cyc%0d got %b want %b", cyc, b_sv, esv(1));
            end
            if (!rel5) begin
                if (a_sid) st5++;
                else begin
                    rel5 = 1; checks++;
                    if (a_sel1 !== 3'd4) begin
                        errors++; $display("FAIL lu_release5_sel got %0d want 4", a_sel1);
                    end
                end
            end
            if (!rel7) begin
                if (b_sid) st7++;
                else begin
                    rel7 = 1; checks++;
                    if (b_sel1 !== 3'd6) begin
                        errors++; $display("FAIL lu_release7_sel got %0d want 6", b_sel1);
                    end
                end
            end
            tick();
        end
        checks++;
        if (!rel5 || !rel7 || st5 != 2 || st7 != 4) begin
            errors++; $display("FAIL lu_stall_len got %0d/%0d want 2/4 (released %0d/%0d)", st5, st7, rel5, rel7);
        end
    endtask

    task automatic test_x0_youngest();
        drain();
        set_id(1, 0, 0, 0, 0, 5'd0, 1, 1);
        tick();
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0);
        #1;
        checks++;
        if (a_sel1 !== 3'd0 || a_sel2 !== 3'd0 || b_sel1 !== 3'd0 || a_ctrl !== 6'd0 || b_ctrl !== 6'd0) begin
            errors++; $display("FAIL x0_nofwd sel %0d/%0d ctrl %b/%b want 0", a_sel1, b_sel1, a_ctrl, b_ctrl);
        end
        tick();
        drain();
        set_id(1, 0, 0, 0, 0, 5'd3, 1, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 5'd3, 1, 0);
        tick();
        set_id(1, 5'd1, 5'd3, 1, 1, 5'd8, 1, 0);
        #1;
        checks++;
        if (a_sel2 !== 3'd2 || b_sel2 !== 3'd2 || a_sel1 !== 3'd0) begin
            errors++; $display("FAIL youngest_wins got %0d/%0d rs1 %0d want 2/2 rs1 0", a_sel2, b_sel2, a_sel1);
        end
        tick();
    endtask

    task automatic test_redirect();
        drain();
        set_id(1, 0, 0, 0, 0, 5'd9, 1, 1);
        tick();
        set_id(1, 5'd9, 0, 1, 0, 5'd10, 1, 0);
        redirect = 1;
        #1;
        checks++;
        if (a_ctrl !== 6'b000110 || b_ctrl !== 6'b000110) begin
            errors++; $display("FAIL redirect_over_lu got %b/%b want 000110", a_ctrl, b_ctrl);
        end
        tick();
        redirect = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (a_sv !== 3'b010 || b_sv !== 5'b00010) begin
            errors++; $display("FAIL redirect_bubble got %b/%b want 010/00010", a_sv, b_sv);
        end
        tick();
    endtask

    task automatic test_memwait();
        logic [2:0] sv5;
        logic [4:0] sv7;
        int         rem5 = 0, rem7 = 0;
        bit         done = 0;
        drain();
        set_id(1, 0, 0, 0, 0, 5'd4, 1, 1);
        tick();
        set_id(1, 5'd4, 0, 1, 0, 5'd11, 1, 0);
        #1;
        checks++;
        if (a_ctrl !== 6'b111000 || b_ctrl !== 6'b111000) begin
            errors++; $display("FAIL mw_pre_stall got %b/%b want 111000", a_ctrl, b_ctrl);
        end
        tick();
        mem_wait = 1;
        sv5 = a_sv; sv7 = b_sv;
        repeat (3) begin
            #1;
            checks++;
            if (a_ctrl !== 6'b110001 || b_ctrl !== 6'b110001 || a_sv !== sv5 || b_sv !== sv7) begin
                errors++; $display("FAIL mw_freeze ctrl %b/%b sv %b/%b want 110001 sv %b/%b", a_ctrl, b_ctrl, a_sv, b_sv, sv5, sv7);
            end
            tick();
        end
        mem_wait = 0;
        for (int cyc = 0; cyc < 10 && !done; cyc++) begin
            #1;
            if (a_sid) rem5++;
            if (b_sid) rem7++;
            done = !a_sid && !b_sid;
            tick();
        end
        checks++;
        if (!done || rem5 != 1 || rem7 != 3) begin
            errors++; $display("FAIL mw_resume got %0d/%0d want 1/3", rem5, rem7);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (a_cmw !== 32'd3 || b_cmw !== 32'd3) begin
            errors++; $display("FAIL cnt_memwait got %0d/%0d want 3", a_cmw, b_cmw);
        end
`endif
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            set_id(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 4)), 1'($urandom),
                   ($urandom_range(0, 2) == 0));
            redirect = ($urandom_range(0, 9) == 0);
            mem_wait = ($urandom_range(0, 7) == 0);
            #1;
            checks++;
            if (a_ctrl !== ectrl(0) || b_ctrl !== ectrl(1)) begin
                errors++; $display("FAIL rnd_ctrl cyc%0d got %b/%b want %b/%b", cyc, a_ctrl, b_ctrl, ectrl(0), ectrl(1));
            end
            checks++;
            if (a_sel1 !== esel(0, id_rs1, id_rs1_used) || a_sel2 !== esel(0, id_rs2, id_rs2_used) ||
                b_sel1 !== esel(1, id_rs1, id_rs1_used) || b_sel2 !== esel(1, id_rs2, id_rs2_used)) begin
                errors++; $display("FAIL rnd_sel cyc%0d got %0d,%0d/%0d,%0d want %0d,%0d/%0d,%0d", cyc,
                    a_sel1, a_sel2, b_sel1, b_sel2, esel(0, id_rs1, id_rs1_used), esel(0, id_rs2, id_rs2_used),
                    esel(1, id_rs1, id_rs1_used), esel(1, id_rs2, id_rs2_used));
            end
            checks++;
            if (8'(a_sv) !== esv(0) || 8'(b_sv) !== esv(1)) begin
                errors++; $display("FAIL rnd_sv cyc%0d got %b/%b want %b/%b", cyc, a_sv, b_sv, esv(0), esv(1));
            end
            tick();
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (a_clu !== 32'(pc_lu[0]) || a_cfl !== 32'(pc_fl[0]) || a_cmw !== 32'(pc_mw[0]) ||
            b_clu !== 32'(pc_lu[1]) || b_cfl !== 32'(pc_fl[1]) || b_cmw !== 32'(pc_mw[1])) begin
            errors++; $display("FAIL rnd_cnt got %0d,%0d,%0d/%0d,%0d,%0d want %0d,%0d,%0d/%0d,%0d,%0d",
                a_clu, a_cfl, a_cmw, b_clu, b_cfl, b_cmw, pc_lu[0], pc_fl[0], pc_mw[0], pc_lu[1], pc_fl[1], pc_mw[1]);
        end
`endif
    endtask

    task automatic test_mid_reset();
        drain();
        for (int i = 0; i < 3; i++) begin
            set_id(1, 0, 0, 0, 0, 5'(i + 1), 1, 0);
            tick();
        end
        set_id(1, 5'd1, 0, 1, 0, 5'd2, 1, 0);
        #2;
        rst = 1'b1;
        mem_wait = 1;
        #1;
        checks++;
        if (a_sv !== 3'd0 || b_sv !== 5'd0 || a_ctrl !== 6'd0 || b_ctrl !== 6'd0 || a_sel1 !== 3'd0) begin
            errors++; $display("FAIL mid_reset sv %b/%b ctrl %b/%b sel %0d want all 0", a_sv, b_sv, a_ctrl, b_ctrl, a_sel1);
        end
        model_clear();
        mem_wait = 0;
        @(negedge clk);
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        test_reset();
        test_fwd_basic();
        test_load_use();
        test_x0_youngest();
        test_redirect();
        test_memwait();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
